// File: rtl/reg_file_sweep.sv
// Multi-read register file with an async-reset array and a self-timed sweep-clear engine.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.

module reg_file_sweep_rdport #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] regs,
    input  logic [ADDR_W-1:0]           addr,
    input  logic                        fwdHit,
    input  logic [WIDTH-1:0]            fwdData,
    output logic [WIDTH-1:0]            dataOut
);
    always_comb begin
        dataOut = regs[addr];
        if (ZERO_REG != 0 && addr == '0) dataOut = '0;
        if (fwdHit) dataOut = fwdData;
    end
endmodule

module reg_file_sweep #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              enableWrite,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [WIDTH-1:0]  writeData,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [ADDR_W-1:0] addrB,
    output logic [WIDTH-1:0]  dataOutA,
    output logic [WIDTH-1:0]  dataOutB,
    input  logic              clearReq,
    output logic              clearBusy,
    output logic              clearDone
);
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t                            state, nextState;
    logic [ADDR_W-1:0]                 counter;
    logic [DEPTH-1:0][WIDTH-1:0]       regs;
    logic                              wrEn;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]  rdAddr;
    logic [NUM_PORTS-1:0][WIDTH-1:0]   rdData;
    logic [NUM_PORTS-1:0]              fwdHit;

    assign clearBusy = (state == SWEEP);
    assign clearDone = (state == DONE);

    // Writes are dropped (not queued) while sweeping; entry 0 is read-only when hardwired.
    assign wrEn = enableWrite && !clearBusy && !(ZERO_REG != 0 && writeAddr == '0);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (clearReq) nextState = SWEEP;
            SWEEP:   if (counter == '1) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && clearReq) counter <= '0;
            else if (state == SWEEP)       counter <= counter + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)              regs <= '0;
        else if (state == SWEEP)  regs[counter] <= '0;
        else if (wrEn)            regs[writeAddr] <= writeData;
    end

    assign rdAddr   = {addrB, addrA};
    assign dataOutA = rdData[0];
    assign dataOutB = rdData[1];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
`ifdef REGFILE_BYPASS_EN
        assign fwdHit[p] = wrEn && (writeAddr == rdAddr[p]);
`else
        assign fwdHit[p] = 1'b0;
`endif
        reg_file_sweep_rdport #(
            .WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)
        ) uPort (
            .regs    (regs),
            .addr    (rdAddr[p]),
            .fwdHit  (fwdHit[p]),
            .fwdData (writeData),
            .dataOut (rdData[p])
        );
    end
endmodule

// File: tb/tb_reg_file_sweep.sv
// Directed bench for reg_file_sweep (32x32, ZERO_REG=1); expectations hand-computed per step.
module tb_reg_file_sweep;
    logic        clk = 1'b0;
    logic        resetN;
    logic        enableWrite;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic [4:0]  addrA, addrB;
    logic [31:0] dataOutA, dataOutB;
    logic        clearReq, clearBusy, clearDone;

    int checks = 0;
    int errors = 0;

    reg_file_sweep dut (
        .clk(clk), .resetN(resetN), .enableWrite(enableWrite), .writeAddr(writeAddr),
        .writeData(writeData), .addrA(addrA), .addrB(addrB), .dataOutA(dataOutA),
        .dataOutB(dataOutB), .clearReq(clearReq), .clearBusy(clearBusy), .clearDone(clearDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    initial begin
        logic [31:0] expA, expB;
        int cnt;
        resetN = 1'b0; enableWrite = 1'b0; writeAddr = '0; writeData = '0;
        addrA = '0; addrB = '0; clearReq = 1'b0;
        #1;
        chk("rst_busy", {31'b0, clearBusy}, 32'd0);
        chk("rst_done", {31'b0, clearDone}, 32'd0);
        @(negedge clk); resetN = 1'b1;

        // every entry reads zero after reset
        for (int k = 0; k < 32; k++) begin
            addrA = 5'(k); addrB = 5'(31 - k); #1;
            chk("rst_readA", dataOutA, 32'd0);
            chk("rst_readB", dataOutB, 32'd0);
        end

        // basic write/read, with same-cycle view depending on forwarding
        @(negedge clk); enableWrite = 1'b1; writeAddr = 5'd5; writeData = 32'hDEADBEEF; addrA = 5'd5; #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_cycle", dataOutA, 32'hDEADBEEF);
`else
        chk("nobyp_old_value", dataOutA, 32'd0);
`endif
        @(negedge clk); writeAddr = 5'd31; writeData = 32'h12345678;
        @(negedge clk); enableWrite = 1'b0; addrA = 5'd5; addrB = 5'd31; #1;
        chk("wr_read5", dataOutA, 32'hDEADBEEF);
        chk("wr_read31", dataOutB, 32'h12345678);
        @(negedge clk); enableWrite = 1'b1; writeAddr = 5'd0; writeData = 32'hFFFFFFFF; addrA = 5'd0; #1;
        chk("zero_fwd_blocked", dataOutA, 32'd0);
        @(negedge clk); enableWrite = 1'b0; #1;
        chk("zero_reg", dataOutA, 32'd0);

        @(negedge clk); enableWrite = 1'b1; writeAddr = 5'd9; writeData = 32'h55; addrA = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_9", dataOutA, 32'h55);
`else
        chk("nobyp_9", dataOutA, 32'd0);
`endif
        @(negedge clk); enableWrite = 1'b0; #1;
        chk("wr_read9", dataOutA, 32'h55);

        // fill 1..31 with index
        for (int k = 1; k < 32; k++) begin
            @(negedge clk); enableWrite = 1'b1; writeAddr = 5'(k); writeData = 32'(k);
        end
        @(negedge clk); enableWrite = 1'b0; addrA = 5'd17; #1;
        chk("fill_17", dataOutA, 32'd17);

        // sweep start collides with a write to entry 3
        @(negedge clk); enableWrite = 1'b1; writeAddr = 5'd3; writeData = 32'hAA; clearReq = 1'b1; addrA = 5'd3; #1;
`ifdef REGFILE_BYPASS_EN
        chk("collide_fwd", dataOutA, 32'hAA);
`else
        chk("collide_old", dataOutA, 32'd3);
`endif
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            clearReq = 1'b0;
            enableWrite = (j == 10); writeAddr = 5'd7; writeData = 32'h777;
            addrA = 5'(j); addrB = 5'(j - 1);
            #1;
            expA = (j == 3) ? 32'hAA : 32'(j);
            expB = (j == 0) ? 32'd31 : 32'd0;
            chk($sformatf("sw_busy_%0d", j), {31'b0, clearBusy}, 32'd1);
            chk($sformatf("sw_done_%0d", j), {31'b0, clearDone}, 32'd0);
            chk($sformatf("sw_unswept_%0d", j), dataOutA, expA);
            chk($sformatf("sw_swept_%0d", j), dataOutB, expB);
        end
        // DONE cycle: write accepted
        @(negedge clk); enableWrite = 1'b1; writeAddr = 5'd3; writeData = 32'hBB; #1;
        chk("done_busy", {31'b0, clearBusy}, 32'd0);
        chk("done_pulse", {31'b0, clearDone}, 32'd1);
        @(negedge clk); enableWrite = 1'b0; addrA = 5'd3; addrB = 5'd7; #1;
        chk("done_drop", {31'b0, clearDone}, 32'd0);
        chk("done_write3", dataOutA, 32'hBB);
        chk("sweep_drop7", dataOutB, 32'd0);
        addrA = 5'd31; addrB = 5'd16; #1;
        chk("swept_31", dataOutA, 32'd0);
        chk("swept_16", dataOutB, 32'd0);

        // reset in the middle of a sweep
        @(negedge clk); enableWrite = 1'b1; writeAddr = 5'd20; writeData = 32'h20;
        @(negedge clk); enableWrite = 1'b0; clearReq = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            @(negedge clk); clearReq = 1'b0;
        end
        resetN = 1'b0; addrA = 5'd20; addrB = 5'd3; #1;
        chk("mid_rst_busy", {31'b0, clearBusy}, 32'd0);
        chk("mid_rst_done", {31'b0, clearDone}, 32'd0);
        chk("mid_rst_20", dataOutA, 32'd0);
        chk("mid_rst_3", dataOutB, 32'd0);
        @(negedge clk); @(negedge clk); #1;
        chk("mid_rst_nodone", {31'b0, clearDone}, 32'd0);
        resetN = 1'b1;

        // restarted sweep begins at entry 0
        @(negedge clk); enableWrite = 1'b1; writeAddr = 5'd1; writeData = 32'h11;
        @(negedge clk); writeAddr = 5'd2; writeData = 32'h22;
        @(negedge clk); enableWrite = 1'b0; clearReq = 1'b1;
        @(negedge clk); clearReq = 1'b0;
        @(negedge clk); addrA = 5'd1; addrB = 5'd2; #1;
        chk("restart_1_kept", dataOutA, 32'h11);
        @(negedge clk); #1;
        chk("restart_1_clr", dataOutA, 32'd0);
        chk("restart_2_kept", dataOutB, 32'h22);
        cnt = 0;
        while (cnt < 40 && !clearDone) begin
            @(negedge clk); #1;
            cnt++;
        end
        chk("restart_done_at", 32'(cnt), 32'd30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
